change_dispenser: RTL and testbench
===================================

# change_dispenser

Returns change after a sale: loads the remaining credit as four BCD digits, in the same digit layout as the credit counter, and pays it out coin by coin. It uses a greedy largest-coin-first order and the same 3-bit coin code the machine accepts on its `money` input. It sits between the credit logic (balance source, triggered on clear/refund) and the physical coin-out mechanism, which acknowledges each coin with a ready/valid handshake.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the dispensed-coin counter.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  request to pay out `bal_3..bal_0`; sampled only in IDLE.
- `bal_0`, `bal_1`, `bal_2`, `bal_3`  in  4 each  BCD digits of the balance, in units of 1, 10, 100 and 1000.
- `coin_ready`  in  1  coin mechanism accepts the offered coin.
- `coin_valid`  out  1  a coin is offered on `coin_code`.
- `coin_code`  out  3  coin value: 000 = 5, 001 = 10, 011 = 20, 100 = 50. Codes 010, 101, 110 and 111 are never driven.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a payout ends.
- `err`  out  1  set when a payout ends abnormally; cleared on the next accepted `start`.
- `remain`  out  14  current binary balance still owed.
- `coin_count`  out  `COUNT_W`  coins transferred in the current or last payout; saturates at all-ones.

## Operation
- States: IDLE, LOAD, SELECT, OFFER, DONE.
- **IDLE**
  - If `start`=1 and all four digits are ≤ 9: `err`←0, `coin_count`←0, go to LOAD.
  - If `start`=1 and any digit is > 9: `err`←1, `remain`←0, go to DONE. No coin is offered.
  - `start` in any other state is ignored.
- **LOAD**: `remain` ← bal_3·1000 + bal_2·100 + bal_1·10 + bal_0, computed from the digits registered at the accepting edge. Maximum value is 9999, which fits 14 bits. Next state is SELECT.
- **SELECT**: picks the largest coin with value ≤ `remain`, in the order 50, 20, 10, 5.
  - If a coin is picked: register its code into `coin_code` and go to OFFER.
  - If `remain`=0: go to DONE.
  - If 0 < `remain` < 5: `err`←1, go to DONE. `remain` holds the unpayable residue.
- **OFFER**: `coin_valid`=1 and `coin_code` held stable.
  - On a cycle with `coin_valid`=1 and `coin_ready`=1 (transfer): `remain` -= coin value, `coin_count` += 1 (saturating), go to SELECT.
  - While `coin_ready`=0, stay in OFFER with all outputs unchanged.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- Subtraction never underflows, because SELECT only picks coins with value ≤ `remain`.

## Timing
- Reset values:
  - state IDLE
  - `coin_valid`=0, `coin_code`=000
  - `busy`=0, `done`=0, `err`=0
  - `remain`=0, `coin_count`=0
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Cycle timing, taking `start` sampled at the edge ending cycle 0:
  - LOAD in cycle 1.
  - SELECT in cycle 2.
  - First `coin_valid`=1 in cycle 3.
- Each coin costs at least 2 cycles (OFFER + SELECT).
- After the last transfer, `done` is asserted 2 cycles later (SELECT, then DONE).
- Zero balance: `done` in cycle 3, no coin offered.
- Invalid BCD digit: `done` in cycle 1.
- Handshake rules:
  - `coin_valid` never drops without a transfer.
  - `coin_code` is constant while `coin_valid`=1.
  - `coin_ready` is ignored when `coin_valid`=0.
- `busy` rises in the cycle after `start` is accepted. It falls in the cycle after DONE.
- Asynchronous `rst` in any state, including mid-OFFER, forces all reset values immediately. A coin that was offered but not acknowledged is dropped and not counted.

## Test plan
- **85 with `coin_ready` tied high**: bal = 0,0,8,5.
  - Required: codes 100, 011, 001, 000 on consecutive offers, in cycles 3, 5, 7, 9.
  - `done` in cycle 11, `coin_count`=4, `remain`=0, `err`=0.
- **Backpressure**: bal = 0,0,2,0 with `coin_ready` low for 5 cycles after `coin_valid` rises.
  - Required: `coin_valid`=1 and `coin_code`=011 stable for 6 cycles.
  - Exactly one transfer, then `done`, `coin_count`=1.
- **Residue**: bal = 0,0,0,7.
  - Required: one coin, code 000, then `done` with `err`=1 and `remain`=2.
- **Invalid digit and zero balance**:
  - bal_1 = 4'hA: `done` in cycle 1 with `err`=1, `coin_valid` never high.
  - Next `start` with bal = 0: `err` clears to 0, `done` in cycle 3, `coin_count`=0.
- **Maximum value**: bal = 9,9,9,5.
  - Required: 199 codes of 100, then 011, 011, 000.
  - `coin_count`=202, `remain`=0.
  - `start` pulses issued mid-payout are ignored.
- **Reset mid-offer**: assert `rst` during the second OFFER of the 85 case.
  - Required: same cycle, `coin_valid`=0, `busy`=0, `remain`=0, `coin_count`=0.
  - After release, a new `start` with bal = 0,0,1,0 dispenses a single code 001.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Bundles the balance request and the coin-out handshake of the change dispenser.
// The master side is the dispenser; the slave side is the credit logic plus coin mechanism.
interface change_dispenser_if #(
  parameter int COUNT_W = 8
) ();
  logic               start;
  logic [3:0]         bal_0;
  logic [3:0]         bal_1;
  logic [3:0]         bal_2;
  logic [3:0]         bal_3;
  logic               coin_ready;
  logic               coin_valid;
  logic [2:0]         coin_code;
  logic               busy;
  logic               done;
  logic               err;
  logic [13:0]        remain;
  logic [COUNT_W-1:0] coin_count;

  modport master (
    input  start, bal_0, bal_1, bal_2, bal_3, coin_ready,
    output coin_valid, coin_code, busy, done, err, remain, coin_count
  );

  modport slave (
    output start, bal_0, bal_1, bal_2, bal_3, coin_ready,
    input  coin_valid, coin_code, busy, done, err, remain, coin_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a four-digit BCD balance as coins, largest first (50, 20, 10, 5),
// one coin per ready/valid transfer; reports unpayable residue or bad digits via err.
module change_dispenser #(
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  change_dispenser_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SELECT,
    OFFER,
    DONE
  } state_e;

  localparam logic [2:0] CODE_5  = 3'b000;
  localparam logic [2:0] CODE_10 = 3'b001;
  localparam logic [2:0] CODE_20 = 3'b011;
  localparam logic [2:0] CODE_50 = 3'b100;

  state_e             state_q;
  logic [15:0]        digits_q;
  logic [13:0]        remain_q;
  logic [2:0]         code_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [COUNT_W-1:0] count_q;

  logic               digits_ok;
  logic [13:0]        load_d;
  logic               pick_ok;
  logic [2:0]         pick_code;
  logic [13:0]        offer_val;
  logic [COUNT_W-1:0] count_d;

  assign digits_ok = (bus.bal_0 <= 4'd9) && (bus.bal_1 <= 4'd9) &&
                     (bus.bal_2 <= 4'd9) && (bus.bal_3 <= 4'd9);

  // Binary balance from the digits captured when start was accepted.
  assign load_d = ({10'd0, digits_q[15:12]} * 14'd1000) +
                  ({10'd0, digits_q[11:8]}  * 14'd100)  +
                  ({10'd0, digits_q[7:4]}   * 14'd10)   +
                   {10'd0, digits_q[3:0]};

  assign count_d = (&count_q) ? count_q : count_q + {{(COUNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    pick_ok   = 1'b1;
    pick_code = CODE_5;
    if (remain_q >= 14'd50) begin
      pick_code = CODE_50;
    end else if (remain_q >= 14'd20) begin
      pick_code = CODE_20;
    end else if (remain_q >= 14'd10) begin
      pick_code = CODE_10;
    end else if (remain_q >= 14'd5) begin
      pick_code = CODE_5;
    end else begin
      pick_ok = 1'b0;
    end
  end

  always_comb begin
    offer_val = 14'd5;
    case (code_q)
      CODE_50: offer_val = 14'd50;
      CODE_20: offer_val = 14'd20;
      CODE_10: offer_val = 14'd10;
      default: offer_val = 14'd5;
    endcase
  end

  // All visible outputs are registered alongside the state so that none of
  // them depends combinationally on start, the digits or coin_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      remain_q <= '0;
      code_q   <= CODE_5;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (digits_ok) begin
              err_q    <= 1'b0;
              count_q  <= '0;
              digits_q <= {bus.bal_3, bus.bal_2, bus.bal_1, bus.bal_0};
              state_q  <= LOAD;
            end else begin
              err_q    <= 1'b1;
              remain_q <= '0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        LOAD: begin
          remain_q <= load_d;
          state_q  <= SELECT;
        end
        SELECT: begin
          if (pick_ok) begin
            code_q  <= pick_code;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end else begin
            // A nonzero balance below the smallest coin cannot be paid out.
            if (remain_q != 14'd0) begin
              err_q <= 1'b1;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        OFFER: begin
          if (bus.coin_ready) begin
            remain_q <= remain_q - offer_val;
            count_q  <= count_d;
            valid_q  <= 1'b0;
            state_q  <= SELECT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.coin_valid = valid_q;
  assign bus.coin_code  = code_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.remain     = remain_q;
  assign bus.coin_count = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a greedy-change reference model predicts
// the coin sequence, residue, error flag and done timing of every payout.
module tb_change_dispenser;

  localparam int COUNT_W = 8;
  localparam int LIMIT   = 4000;
  localparam int COIN_VAL[4]  = '{50, 20, 10, 5};
  localparam int COIN_CODE[4] = '{4, 3, 1, 0};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  change_dispenser_if #(.COUNT_W(COUNT_W)) bus ();

  change_dispenser #(.COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  int expCodes[$];
  int expResidue;
  bit expInvalid;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Greedy change computed directly from the decimal value of the digits.
  task automatic buildModel(input logic [3:0] b3, input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0);
    int v;
    int k;
    expCodes.delete();
    expInvalid = (b3 > 9) || (b2 > 9) || (b1 > 9) || (b0 > 9);
    expResidue = 0;
    if (!expInvalid) begin
      v = int'(b3) * 1000 + int'(b2) * 100 + int'(b1) * 10 + int'(b0);
      while (v >= 5) begin
        k = 0;
        while (COIN_VAL[k] > v) k++;
        expCodes.push_back(COIN_CODE[k]);
        v -= COIN_VAL[k];
      end
      expResidue = v;
    end
  endtask

  // One complete payout: start, randomized coin_ready, then compare against the model.
  task automatic applyStimulus(input logic [3:0] b3, input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0,
                               input int readyPct, input int holdOff, input bit noisyStart);
    int  gotCodes[$];
    int  stalls       = 0;
    int  firstValid   = -1;
    int  doneCycle    = -1;
    int  firstOffer   = 0;
    bit  prevValid    = 1'b0;
    bit  prevXfer     = 1'b0;
    int  prevCode     = 0;
    bit  ready;
    int  n;
    int  expDone;

    buildModel(b3, b2, b1, b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bal_3 = b3;
    bus.bal_2 = b2;
    bus.bal_1 = b1;
    bus.bal_0 = b0;

    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (noisyStart) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.bal_3 = 4'($urandom_range(0, 15));
        bus.bal_2 = 4'($urandom_range(0, 15));
        bus.bal_1 = 4'($urandom_range(0, 15));
        bus.bal_0 = 4'($urandom_range(0, 15));
      end
      if (prevValid && !prevXfer) begin
        checkOutput("valid held", bus.coin_valid, 1);
        checkOutput("code held", bus.coin_code, prevCode);
      end
      checkOutput("busy during payout", bus.busy, 1);
      if (bus.coin_valid && firstValid < 0) firstValid = cyc;
      if (bus.done) begin
        doneCycle      = cyc;
        bus.start      = 1'b0;
        bus.coin_ready = 1'b0;
        break;
      end
      if (bus.coin_valid && gotCodes.size() == 0 && firstOffer < holdOff) ready = 1'b0;
      else ready = ($urandom_range(1, 100) <= readyPct);
      bus.coin_ready = ready;
      if (bus.coin_valid) begin
        if (gotCodes.size() == 0) firstOffer++;
        if (ready) gotCodes.push_back(int'(bus.coin_code));
        else stalls++;
      end
      prevValid = bus.coin_valid;
      prevXfer  = bus.coin_valid && ready;
      prevCode  = int'(bus.coin_code);
    end

    if (doneCycle < 0) begin
      checkOutput("done timeout", 0, 1);
    end else begin
      expDone = expInvalid ? 1 : 3 + 2 * expCodes.size() + stalls;
      checkOutput("done cycle", doneCycle, expDone);
      checkOutput("err", bus.err, (expInvalid || expResidue > 0) ? 1 : 0);
      checkOutput("remain", bus.remain, expResidue);
      if (!expInvalid) checkOutput("coin_count", bus.coin_count, expCodes.size());
      checkOutput("coins transferred", gotCodes.size(), expCodes.size());
      n = (gotCodes.size() < expCodes.size()) ? gotCodes.size() : expCodes.size();
      for (int i = 0; i < n; i++) checkOutput($sformatf("coin %0d code", i), gotCodes[i], expCodes[i]);
      checkOutput("first offer cycle", firstValid, (expCodes.size() > 0) ? 3 : -1);
      if (holdOff > 0 && readyPct == 100) checkOutput("first offer length", firstOffer, holdOff + 1);
    end
    @(negedge clk);
    checkOutput("done one cycle", bus.done, 0);
    checkOutput("busy after done", bus.busy, 0);
  endtask

  // Asynchronous reset while the second coin of an 85 payout is on offer.
  task automatic resetMidOffer();
    @(negedge clk);
    bus.start = 1'b1;
    bus.bal_3 = 4'd0;
    bus.bal_2 = 4'd0;
    bus.bal_1 = 4'd8;
    bus.bal_0 = 4'd5;
    bus.coin_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("second offer valid", bus.coin_valid, 1);
    checkOutput("second offer code", bus.coin_code, 3);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst valid", bus.coin_valid, 0);
    checkOutput("rst busy", bus.busy, 0);
    checkOutput("rst remain", bus.remain, 0);
    checkOutput("rst coin_count", bus.coin_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.coin_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] d[4];
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.bal_0      = 4'd0;
    bus.bal_1      = 4'd0;
    bus.bal_2      = 4'd0;
    bus.bal_3      = 4'd0;
    bus.coin_ready = 1'b0;
    #12;
    checkOutput("reset coin_valid", bus.coin_valid, 0);
    checkOutput("reset coin_code", bus.coin_code, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset err", bus.err, 0);
    checkOutput("reset remain", bus.remain, 0);
    checkOutput("reset coin_count", bus.coin_count, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'd0, 4'd0, 4'd8, 4'd5, 100, 0, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'd2, 4'd0, 100, 5, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd7, 100, 0, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'hA, 4'd0, 100, 0, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 100, 0, 1'b0);
    applyStimulus(4'd9, 4'd9, 4'd9, 4'd5, 100, 0, 1'b1);
    resetMidOffer();
    applyStimulus(4'd0, 4'd0, 4'd1, 4'd0, 100, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 31) == 0) d[j] = 4'($urandom_range(10, 15));
        else if (j >= 2 && $urandom_range(0, 1) == 0) d[j] = 4'd0;
        else d[j] = 4'($urandom_range(0, 9));
      end
      applyStimulus(d[3], d[2], d[1], d[0], $urandom_range(20, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
